// File: rtl/tow_push_arbiter.sv
// -----------------------------------------------------------------------------
// tow_push_arbiter
//
// Front end for the tug-of-war game FSM. Synchronises the two raw push-buttons,
// detects their rising edges, decides who pushed first and emits one move
// pulse per round. It then holds a timed dark window and re-arms only once
// both buttons are released.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   pbl      in   raw left push-button (async, active high)
//   pbr      in   raw right push-button (async, active high)
//   play_en  in   high while the game is in a playable position
//   push_l   out  one-cycle pulse, move marker left
//   push_r   out  one-cycle pulse, move marker right
//   tie      out  one-cycle pulse, both edges in the same cycle
//   dark     out  high during the dark (blanked) window
//
// Build option:
//   TOW_FALSE_START_EN  when defined, a single-player edge during DARK awards a
//                       move to the opponent and restarts the dark window.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | armed, waiting for the first rising edge while play_en is high
// DARK     | move issued, dark window counting down
// WAIT_REL | dark window over, waiting for both buttons to be released
// -----------------------------------------------------------------------------
module tow_push_arbiter #(
    parameter int DARK_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic play_en,
    output logic push_l,
    output logic push_r,
    output logic tie,
    output logic dark
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DARK     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DARK_CYCLES - 1);

    logic       meta_l_q, meta_r_q;
    logic       sync_l_q, sync_r_q;
    logic       prev_l_q, prev_r_q;
    logic [2:0] settle_q;
    logic       edge_l, edge_r;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_l_q, push_r_q, tie_q, dark_q;

    // Synchroniser and edge history. settle_q masks edges until the
    // history holds samples taken after reset, so a button already held
    // when reset releases never looks like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_l_q <= 1'b0;
            meta_r_q <= 1'b0;
            sync_l_q <= 1'b0;
            sync_r_q <= 1'b0;
            prev_l_q <= 1'b0;
            prev_r_q <= 1'b0;
            settle_q <= 3'b000;
        end else begin
            meta_l_q <= pbl;
            meta_r_q <= pbr;
            sync_l_q <= meta_l_q;
            sync_r_q <= meta_r_q;
            prev_l_q <= sync_l_q;
            prev_r_q <= sync_r_q;
            settle_q <= {settle_q[1:0], 1'b1};
        end
    end

    assign edge_l = sync_l_q & ~prev_l_q & settle_q[2];
    assign edge_r = sync_r_q & ~prev_r_q & settle_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            push_l_q <= 1'b0;
            push_r_q <= 1'b0;
            tie_q    <= 1'b0;
            dark_q   <= 1'b0;
        end else begin
            push_l_q <= 1'b0;
            push_r_q <= 1'b0;
            tie_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (play_en && (edge_l || edge_r)) begin
                        if (edge_l && edge_r) begin
                            tie_q <= 1'b1;
                        end else if (edge_l) begin
                            push_l_q <= 1'b1;
                        end else begin
                            push_r_q <= 1'b1;
                        end
                        cnt_q   <= CNT_LOAD;
                        dark_q  <= 1'b1;
                        state_q <= DARK;
                    end
                end
                DARK: begin
                    if (!play_en) begin
                        cnt_q   <= '0;
                        dark_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef TOW_FALSE_START_EN
                    end else if (edge_l ^ edge_r) begin
                        // False start: the opponent gets the move.
                        push_r_q <= edge_l;
                        push_l_q <= edge_r;
                        cnt_q    <= CNT_LOAD;
`endif
                    end else if (cnt_q == '0) begin
                        dark_q  <= 1'b0;
                        state_q <= (sync_l_q || sync_r_q) ? WAIT_REL : IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!play_en || (!sync_l_q && !sync_r_q)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    dark_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign push_l = push_l_q;
    assign push_r = push_r_q;
    assign tie    = tie_q;
    assign dark   = dark_q;

endmodule

// File: tb/tb_tow_push_arbiter.sv
module tb_tow_push_arbiter;

    localparam int D = 8;
`ifdef TOW_FALSE_START_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pbl = 1'b0;
    logic pbr = 1'b0;
    logic play_en = 1'b0;
    logic push_l, push_r, tie, dark;

    tow_push_arbiter #(.DARK_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .play_en(play_en),
        .push_l(push_l), .push_r(push_r), .tie(tie), .dark(dark)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: raw samples newest first; a synchronised level is the
    // sample taken two edges earlier, and a press is a 1 following a 0 that
    // was itself sampled after reset (pre-reset history counts as pressed).
    bit raw_l[$];
    bit raw_r[$];
    int mode = 0;          // 0 idle, 1 dark, 2 waiting for release
    int dark_left = 0;     // dark cycles still to show, including the current one
    bit e_pl, e_pr, e_t, e_d;

    function automatic void model_reset();
        raw_l.delete();
        raw_r.delete();
        mode = 0;
        dark_left = 0;
        e_pl = 0; e_pr = 0; e_t = 0; e_d = 0;
    endfunction

    function automatic void model_step();
        bit sl, sr, el, er;
        sl = (raw_l.size() > 1) ? raw_l[1] : 1'b0;
        sr = (raw_r.size() > 1) ? raw_r[1] : 1'b0;
        el = sl && (raw_l.size() > 2) && !raw_l[2];
        er = sr && (raw_r.size() > 2) && !raw_r[2];
        e_pl = 0; e_pr = 0; e_t = 0;
        case (mode)
            0: if (play_en && (el || er)) begin
                mode = 1;
                dark_left = D;
                if (el && er) e_t = 1;
                else if (el)  e_pl = 1;
                else          e_pr = 1;
            end
            1: begin
                if (!play_en) mode = 0;
                else if (FS && (el != er)) begin
                    dark_left = D;
                    e_pr = el;
                    e_pl = er;
                end else if (dark_left == 1) mode = (sl || sr) ? 2 : 0;
                else dark_left = dark_left - 1;
            end
            default: if (!play_en || (!sl && !sr)) mode = 0;
        endcase
        e_d = (mode == 1);
        raw_l.push_front(pbl);
        raw_r.push_front(pbr);
        if (raw_l.size() > 3) void'(raw_l.pop_back());
        if (raw_r.size() > 3) void'(raw_r.pop_back());
    endfunction

    int cnt_pl, cnt_pr, cnt_t, cnt_dark, dark_run;

    task automatic clear_counts();
        cnt_pl = 0; cnt_pr = 0; cnt_t = 0; cnt_dark = 0; dark_run = 0;
    endtask

    // Inputs are already set (at a falling edge); advance one clock and
    // compare against the model at the next falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("push_l", push_l, e_pl);
        check("push_r", push_r, e_pr);
        check("tie", tie, e_t);
        check("dark", dark, e_d);
        check("onehot", (int'(push_l) + int'(push_r) + int'(tie)) <= 1, 1);
        cnt_pl += push_l;
        cnt_pr += push_r;
        cnt_t  += tie;
        cnt_dark += dark;
        if (push_l || push_r || tie) dark_run = dark;
        else if (dark) dark_run++;
    endtask

    task automatic idle(input int n);
        pbl = 0; pbr = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        bit pbl, pbr, pe;
        bit pl, pr, t, d;
    } vec_t;
    vec_t vt[$];

    function automatic void add(bit l, bit r, bit pe, bit pl, bit pr, bit t, bit d);
        vec_t v;
        v.pbl = l; v.pbr = r; v.pe = pe; v.pl = pl; v.pr = pr; v.t = t; v.d = d;
        vt.push_back(v);
    endfunction

    initial begin
        // Single left press, then simultaneous press.
        add(1,0,1, 0,0,0,0);
        add(0,0,1, 0,0,0,0);
        add(0,0,1, 1,0,0,1);
        for (int i = 0; i < D - 1; i++) add(0,0,1, 0,0,0,1);
        add(0,0,1, 0,0,0,0);
        add(1,1,1, 0,0,0,0);
        add(0,0,1, 0,0,0,0);
        add(0,0,1, 0,0,1,1);
        for (int i = 0; i < D - 1; i++) add(0,0,1, 0,0,0,1);
        add(0,0,1, 0,0,0,0);
        add(0,0,1, 0,0,0,0);

        model_reset();
        #12;
        check("rst_push_l", push_l, 0);
        check("rst_push_r", push_r, 0);
        check("rst_tie", tie, 0);
        check("rst_dark", dark, 0);
        @(negedge clk);
        rst = 1;
        play_en = 1;
        idle(5);

        foreach (vt[i]) begin
            pbl = vt[i].pbl; pbr = vt[i].pbr; play_en = vt[i].pe;
            cycle();
            check($sformatf("vec%0d_push_l", i), push_l, vt[i].pl);
            check($sformatf("vec%0d_push_r", i), push_r, vt[i].pr);
            check($sformatf("vec%0d_tie", i), tie, vt[i].t);
            check($sformatf("vec%0d_dark", i), dark, vt[i].d);
        end

        // Left first, right one cycle later and held past the dark window.
        idle(3);
        clear_counts();
        pbl = 1; cycle();
        pbl = 0; pbr = 1;
        for (int i = 0; i < 16; i++) cycle();
        check("late_r_push_l", cnt_pl, FS ? 2 : 1);
        check("late_r_push_r", cnt_pr, 0);
        check("late_r_tie", cnt_t, 0);
        check("late_r_dark_run", dark_run, D);
        check("wait_rel_dark", dark, 0);
        idle(4);
        clear_counts();
        pbr = 1; cycle();
        idle(4);
        check("rearm_push_r", cnt_pr, 1);
        idle(D + 4);

        // play_en low: toggling is ignored.
        clear_counts();
        play_en = 0;
        for (int k = 0; k < 4; k++) begin
            pbl = 1; pbr = k[0]; cycle(); cycle();
            pbl = 0; pbr = 0; cycle(); cycle();
        end
        idle(3);
        check("noplay_pulses", cnt_pl + cnt_pr + cnt_t, 0);
        check("noplay_dark", cnt_dark, 0);
        play_en = 1;
        idle(2);
        pbr = 1; cycle();
        idle(4);
        check("play_push_r", cnt_pr, 1);
        idle(D + 4);

        // Async reset mid-window with the left button then held.
        clear_counts();
        pbl = 1; cycle();
        pbl = 0;
        for (int i = 0; i < 6; i++) cycle();
        check("pre_rst_dark", dark, 1);
        pbl = 1;
        #2 rst = 0;
        #1;
        check("async_push_l", push_l, 0);
        check("async_push_r", push_r, 0);
        check("async_tie", tie, 0);
        check("async_dark", dark, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        clear_counts();
        for (int i = 0; i < 10; i++) cycle();
        check("held_after_rst", cnt_pl, 0);
        idle(3);
        pbl = 1; cycle();
        idle(5);
        check("repress_after_rst", cnt_pl, 1);
        idle(D + 4);

        // Right edge arrives in the 4th dark cycle.
        clear_counts();
        pbl = 1; cycle();
        pbl = 0; cycle();
        cycle();
        pbr = 1; cycle(); cycle();
        pbr = 0;
        for (int i = 0; i < 20; i++) cycle();
        check("fs_push_l", cnt_pl, FS ? 2 : 1);
        check("fs_push_r", cnt_pr, 0);
        check("fs_dark_run", dark_run, D);
        check("fs_dark_total", cnt_dark, FS ? D + 3 : D);
        idle(4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) pbl = ~pbl;
            if ($urandom_range(5) == 0) pbr = ~pbr;
            if (play_en) begin
                if ($urandom_range(39) == 0) play_en = 0;
            end else if ($urandom_range(3) == 0) play_en = 1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
